// File: rtl/e603_icb_ram_arbiter.sv
// Two-master round-robin ICB arbiter in front of a single in-order ICB RAM slave.
// Grant owners are queued in an ID FIFO so each response returns to the master that issued it.
module e603_icb_ram_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic            m0_icb_cmd_read,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic [DW-1:0]   m0_icb_rsp_rdata,
    output logic            m0_icb_rsp_err,

    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic            m1_icb_cmd_read,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic [DW-1:0]   m1_icb_rsp_rdata,
    output logic            m1_icb_rsp_err,

    output logic            s_icb_cmd_valid,
    input  logic            s_icb_cmd_ready,
    output logic            s_icb_cmd_read,
    output logic [AW-1:0]   s_icb_cmd_addr,
    output logic [DW-1:0]   s_icb_cmd_wdata,
    output logic [DW/8-1:0] s_icb_cmd_wmask,
    input  logic            s_icb_rsp_valid,
    output logic            s_icb_rsp_ready,
    input  logic [DW-1:0]   s_icb_rsp_rdata,
    input  logic            s_icb_rsp_err,

    output logic            arb_orphan_err
);

    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CW = $clog2(OUTS_DEPTH + 1);

    logic                  rr_last;
    logic [OUTS_DEPTH-1:0] id_fifo;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  orphan;

    logic grant;
    logic full;
    logic empty;
    logic cmd_fire;
    logic rsp_fire;
    logic head_owner;

    // Tie goes to the master not granted last; idle defaults the payload mux to m0.
    always_comb begin
        grant = 1'b0;
        if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            grant = ~rr_last;
        end else if (m1_icb_cmd_valid) begin
            grant = 1'b1;
        end
    end

    assign full  = (count == CW'(OUTS_DEPTH));
    assign empty = (count == '0);

    assign s_icb_cmd_valid = (m0_icb_cmd_valid | m1_icb_cmd_valid) & ~full;
    assign s_icb_cmd_read  = grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_addr  = grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_wdata = grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask = grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    assign m0_icb_cmd_ready = ~grant & s_icb_cmd_ready & ~full;
    assign m1_icb_cmd_ready =  grant & s_icb_cmd_ready & ~full;

    assign cmd_fire = s_icb_cmd_valid & s_icb_cmd_ready;

    assign head_owner = id_fifo[rd_ptr];

    assign m0_icb_rsp_valid = s_icb_rsp_valid & ~empty & ~head_owner;
    assign m1_icb_rsp_valid = s_icb_rsp_valid & ~empty &  head_owner;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;

    // With nothing outstanding the response is accepted and discarded.
    assign s_icb_rsp_ready = empty ? 1'b1 : (head_owner ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    assign rsp_fire        = s_icb_rsp_valid & s_icb_rsp_ready & ~empty;

    assign arb_orphan_err = orphan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            orphan  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                id_fifo[wr_ptr] <= grant;
                wr_ptr          <= (wr_ptr == PW'(OUTS_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                rr_last         <= grant;
            end
            if (rsp_fire) begin
                rd_ptr <= (rd_ptr == PW'(OUTS_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({cmd_fire, rsp_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_icb_rsp_valid && empty) begin
                orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_e603_icb_ram_arbiter.sv
// Scenario bench for the two-master ICB RAM arbiter; expected responses are queued at command time.
module tb_e603_icb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;

    logic            m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [AW-1:0]   m0_icb_cmd_addr;
    logic [DW-1:0]   m0_icb_cmd_wdata;
    logic [DW/8-1:0] m0_icb_cmd_wmask;
    logic            m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
    logic [DW-1:0]   m0_icb_rsp_rdata;

    logic            m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [AW-1:0]   m1_icb_cmd_addr;
    logic [DW-1:0]   m1_icb_cmd_wdata;
    logic [DW/8-1:0] m1_icb_cmd_wmask;
    logic            m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
    logic [DW-1:0]   m1_icb_rsp_rdata;

    logic            s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
    logic [AW-1:0]   s_icb_cmd_addr;
    logic [DW-1:0]   s_icb_cmd_wdata;
    logic [DW/8-1:0] s_icb_cmd_wmask;
    logic            s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
    logic [DW-1:0]   s_icb_rsp_rdata;
    logic            arb_orphan_err;

    typedef struct packed {
        logic          owner;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t exp_r;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    e603_icb_ram_arbiter #(.AW(AW), .DW(DW), .OUTS_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
        .m0_icb_rsp_rdata(m0_icb_rsp_rdata), .m0_icb_rsp_err(m0_icb_rsp_err),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
        .m1_icb_rsp_rdata(m1_icb_rsp_rdata), .m1_icb_rsp_err(m1_icb_rsp_err),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_read(s_icb_cmd_read), .s_icb_cmd_addr(s_icb_cmd_addr),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err),
        .arb_orphan_err(arb_orphan_err)
    );

    task automatic idle_inputs();
        m0_icb_cmd_valid = 1'b0; m0_icb_cmd_read = 1'b1; m0_icb_cmd_addr = '0;
        m0_icb_cmd_wdata = '0;   m0_icb_cmd_wmask = '1;  m0_icb_rsp_ready = 1'b1;
        m1_icb_cmd_valid = 1'b0; m1_icb_cmd_read = 1'b1; m1_icb_cmd_addr = '0;
        m1_icb_cmd_wdata = '0;   m1_icb_cmd_wmask = '1;  m1_icb_rsp_ready = 1'b1;
        s_icb_cmd_ready  = 1'b1; s_icb_rsp_valid = 1'b0; s_icb_rsp_rdata = '0;
        s_icb_rsp_err    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({s_icb_cmd_valid, m0_icb_rsp_valid, m1_icb_rsp_valid, arb_orphan_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {s_icb_cmd_valid, m0_icb_rsp_valid, m1_icb_rsp_valid, arb_orphan_err});
        end
        total++;
        if (s_icb_rsp_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_rsp_ready got=%b exp=1", s_icb_rsp_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b1; m0_icb_cmd_addr = 12'h010;
        #1;
        total++;
        if ({m1_icb_cmd_ready, m0_icb_cmd_ready, s_icb_cmd_valid, s_icb_cmd_read, s_icb_cmd_addr}
            !== {1'b0, 1'b1, 1'b1, 1'b1, 12'h010}) begin
            bad++;
            $display("FAIL single_cmd got=%b_%b_%b_%b_%h exp=0_1_1_1_010", m1_icb_cmd_ready,
                     m0_icb_cmd_ready, s_icb_cmd_valid, s_icb_cmd_read, s_icb_cmd_addr);
        end
        sb.push_back('{owner: 1'b0, data: 32'hDEADBEEF, err: 1'b0});
        @(negedge clk);
        m0_icb_cmd_valid = 1'b0;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = sb[0].data; s_icb_rsp_err = sb[0].err;
        #1;
        exp_r = sb.pop_front();
        total++;
        if ({m1_icb_rsp_valid, m0_icb_rsp_valid, s_icb_rsp_ready} !== 3'b011) begin
            bad++;
            $display("FAIL single_rsp_route got=%b exp=011",
                     {m1_icb_rsp_valid, m0_icb_rsp_valid, s_icb_rsp_ready});
        end
        total++;
        if (m0_icb_rsp_rdata !== exp_r.data) begin
            bad++;
            $display("FAIL single_rsp_data got=%h exp=%h", m0_icb_rsp_rdata, exp_r.data);
        end
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
        #1;
        total++;
        if ({m1_icb_rsp_valid, m0_icb_rsp_valid} !== 2'b00) begin
            bad++;
            $display("FAIL single_rsp_idle got=%b exp=00", {m1_icb_rsp_valid, m0_icb_rsp_valid});
        end
    endtask

    task automatic test_round_robin();
        logic          g;
        logic [AW-1:0] ea;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            m0_icb_cmd_valid = (k < 4); m0_icb_cmd_addr = AW'(12'h100 + k);
            m1_icb_cmd_valid = (k < 4); m1_icb_cmd_addr = AW'(12'h200 + k);
            s_icb_rsp_valid = (k > 0);
            if (k > 0) s_icb_rsp_rdata = sb[0].data;
            #1;
            if (k < 4) begin
                g  = ((k % 2) == 1);
                ea = g ? AW'(12'h200 + k) : AW'(12'h100 + k);
                total++;
                if ({s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready} !== {1'b1, g, ~g}) begin
                    bad++;
                    $display("FAIL rr_grant[%0d] got=%b exp=%b", k,
                             {s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready}, {1'b1, g, ~g});
                end
                total++;
                if (s_icb_cmd_addr !== ea) begin
                    bad++;
                    $display("FAIL rr_addr[%0d] got=%h exp=%h", k, s_icb_cmd_addr, ea);
                end
                sb.push_back('{owner: g, data: DW'(32'hA000_0000 + k), err: 1'b0});
            end
            if (k > 0) begin
                exp_r = sb.pop_front();
                total++;
                if ({m1_icb_rsp_valid, m0_icb_rsp_valid} !== {exp_r.owner, ~exp_r.owner}) begin
                    bad++;
                    $display("FAIL rr_rsp_route[%0d] got=%b exp=%b", k,
                             {m1_icb_rsp_valid, m0_icb_rsp_valid}, {exp_r.owner, ~exp_r.owner});
                end
                total++;
                if ((exp_r.owner ? m1_icb_rsp_rdata : m0_icb_rsp_rdata) !== exp_r.data) begin
                    bad++;
                    $display("FAIL rr_rsp_data[%0d] got=%h exp=%h", k,
                             exp_r.owner ? m1_icb_rsp_rdata : m0_icb_rsp_rdata, exp_r.data);
                end
            end
        end
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
    endtask

    task automatic test_outstanding_limit();
        logic acc, g;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = AW'(12'h300 + c);
            m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = AW'(12'h400 + c);
            #1;
            acc = (c < 2);
            g   = (c == 1);
            total++;
            if ({s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready} !== {acc, acc & g, acc & ~g}) begin
                bad++;
                $display("FAIL limit_cmd[%0d] got=%b exp=%b", c,
                         {s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready}, {acc, acc & g, acc & ~g});
            end
            if (acc) sb.push_back('{owner: g, data: DW'(32'hB000_0000 + c), err: 1'b0});
        end
        // release one response: still full in this cycle
        @(negedge clk);
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = sb[0].data;
        #1;
        exp_r = sb.pop_front();
        total++;
        if ({s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready, m1_icb_rsp_valid, m0_icb_rsp_valid}
            !== {3'b000, exp_r.owner, ~exp_r.owner}) begin
            bad++;
            $display("FAIL limit_pop_cycle got=%b exp=%b",
                     {s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready, m1_icb_rsp_valid, m0_icb_rsp_valid},
                     {3'b000, exp_r.owner, ~exp_r.owner});
        end
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
        #1;
        total++;
        if ({s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready} !== 3'b101) begin
            bad++;
            $display("FAIL limit_third_cmd got=%b exp=101",
                     {s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready});
        end
        sb.push_back('{owner: 1'b0, data: 32'hB000_0004, err: 1'b0});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
            s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = sb[0].data;
            #1;
            exp_r = sb.pop_front();
            total++;
            if ({m1_icb_rsp_valid, m0_icb_rsp_valid, s_icb_rsp_rdata == exp_r.data}
                !== {exp_r.owner, ~exp_r.owner, 1'b1}) begin
                bad++;
                $display("FAIL limit_drain[%0d] got=%b exp=%b", c,
                         {m1_icb_rsp_valid, m0_icb_rsp_valid}, {exp_r.owner, ~exp_r.owner});
            end
        end
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
    endtask

    task automatic test_write_backpressure();
        @(negedge clk);
        m1_icb_cmd_valid = 1'b1; m1_icb_cmd_read = 1'b0; m1_icb_cmd_addr = 12'h004;
        m1_icb_cmd_wdata = 32'h12345678; m1_icb_cmd_wmask = 4'b0011;
        #1;
        total++;
        if ({m1_icb_cmd_ready, m0_icb_cmd_ready, s_icb_cmd_read, s_icb_cmd_addr, s_icb_cmd_wdata, s_icb_cmd_wmask}
            !== {1'b1, 1'b0, 1'b0, 12'h004, 32'h12345678, 4'b0011}) begin
            bad++;
            $display("FAIL wr_payload got=%b%b_%b_%h_%h_%b exp=10_0_004_12345678_0011",
                     m1_icb_cmd_ready, m0_icb_cmd_ready, s_icb_cmd_read, s_icb_cmd_addr,
                     s_icb_cmd_wdata, s_icb_cmd_wmask);
        end
        sb.push_back('{owner: 1'b1, data: 32'h0000_0000, err: 1'b0});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            m1_icb_cmd_valid = 1'b0; m1_icb_cmd_read = 1'b1;
            m1_icb_rsp_ready = (c == 3);
            s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = sb[0].data; s_icb_rsp_err = 1'b0;
            #1;
            total++;
            if ({m1_icb_rsp_valid, m0_icb_rsp_valid, s_icb_rsp_ready} !== {2'b10, (c == 3)}) begin
                bad++;
                $display("FAIL wr_rsp_hold[%0d] got=%b exp=%b", c,
                         {m1_icb_rsp_valid, m0_icb_rsp_valid, s_icb_rsp_ready}, {2'b10, (c == 3)});
            end
        end
        exp_r = sb.pop_front();
        total++;
        if (m1_icb_rsp_err !== exp_r.err) begin
            bad++;
            $display("FAIL wr_rsp_err got=%b exp=%b", m1_icb_rsp_err, exp_r.err);
        end
        @(negedge clk);
        s_icb_rsp_valid = 1'b0; m1_icb_rsp_ready = 1'b1;
        #1;
        total++;
        if (arb_orphan_err !== 1'b0) begin
            bad++;
            $display("FAIL wr_no_orphan got=%b exp=0", arb_orphan_err);
        end
    endtask

    task automatic test_orphan();
        @(negedge clk);
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h0BAD_0BAD;
        #1;
        total++;
        if ({s_icb_rsp_ready, m1_icb_rsp_valid, m0_icb_rsp_valid, arb_orphan_err} !== 4'b1000) begin
            bad++;
            $display("FAIL orphan_drain got=%b exp=1000",
                     {s_icb_rsp_ready, m1_icb_rsp_valid, m0_icb_rsp_valid, arb_orphan_err});
        end
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (arb_orphan_err !== 1'b1) begin
            bad++;
            $display("FAIL orphan_sticky got=%b exp=1", arb_orphan_err);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (arb_orphan_err !== 1'b0) begin
            bad++;
            $display("FAIL orphan_reset_clear got=%b exp=0", arb_orphan_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            m0_icb_cmd_valid = 1'b1; m1_icb_cmd_valid = 1'b1;
            #1;
            total++;
            if ({m1_icb_cmd_ready, m0_icb_cmd_ready} !== ((c == 1) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL mid_fill[%0d] got=%b exp=%b", c,
                         {m1_icb_cmd_ready, m0_icb_cmd_ready}, (c == 1) ? 2'b10 : 2'b01);
            end
        end
        @(negedge clk);
        m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_icb_rsp_ready, arb_orphan_err} !== 2'b10) begin
            bad++;
            $display("FAIL mid_reset_state got=%b exp=10", {s_icb_rsp_ready, arb_orphan_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h5A5A_5A5A;
        #1;
        total++;
        if ({s_icb_rsp_ready, m1_icb_rsp_valid, m0_icb_rsp_valid} !== 3'b100) begin
            bad++;
            $display("FAIL mid_stale_rsp got=%b exp=100",
                     {s_icb_rsp_ready, m1_icb_rsp_valid, m0_icb_rsp_valid});
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            s_icb_rsp_valid = 1'b0;
            m0_icb_cmd_valid = 1'b1; m1_icb_cmd_valid = 1'b1;
            #1;
            total++;
            if ({arb_orphan_err, s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready}
                !== ((c == 1) ? 4'b1110 : 4'b1101)) begin
                bad++;
                $display("FAIL mid_post_grant[%0d] got=%b exp=%b", c,
                         {arb_orphan_err, s_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready},
                         (c == 1) ? 4'b1110 : 4'b1101);
            end
            sb.push_back('{owner: (c == 1), data: DW'(32'hC000_0000 + c), err: 1'b0});
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
            s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = sb[0].data;
            #1;
            exp_r = sb.pop_front();
            total++;
            if ({m1_icb_rsp_valid, m0_icb_rsp_valid, s_icb_rsp_ready} !== {exp_r.owner, ~exp_r.owner, 1'b1}) begin
                bad++;
                $display("FAIL mid_drain[%0d] got=%b exp=%b", c,
                         {m1_icb_rsp_valid, m0_icb_rsp_valid, s_icb_rsp_ready}, {exp_r.owner, ~exp_r.owner, 1'b1});
            end
        end
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_outstanding_limit();
        test_write_backpressure();
        test_orphan();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e603_icb_ram_arbiter.md
Name: e603_icb_ram_arbiter

Overview:
- Two-master ICB arbiter that shares one ICB SRAM slave port (the e603 ICB RAM top instance) between two requesters, e.g. core data port and a debug/DMA port.
- Arbitrates commands round-robin.
- Records the grant owner of every accepted command in an in-order ID FIFO and routes each slave response back to its owner.
- Sits directly in front of the RAM slave; the slave returns responses in order, at least 1 cycle after command acceptance.

Parameters:
AW, 12, ICB address width (byte address).
DW, 32, ICB data width; wmask width is DW/8.
OUTS_DEPTH, 2, max outstanding commands (ID FIFO depth, >=1).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
m0_icb_cmd_valid  input  1  master 0 command valid
m0_icb_cmd_ready  output  1  master 0 command ready
m0_icb_cmd_read  input  1  master 0 read (1) / write (0)
m0_icb_cmd_addr  input  AW  master 0 address
m0_icb_cmd_wdata  input  DW  master 0 write data
m0_icb_cmd_wmask  input  DW/8  master 0 byte mask
m0_icb_rsp_valid  output  1  master 0 response valid
m0_icb_rsp_ready  input  1  master 0 response ready
m0_icb_rsp_rdata  output  DW  master 0 read data
m0_icb_rsp_err  output  1  master 0 response error
m1_icb_* (same 10 signals, same directions/widths)  master 1
s_icb_cmd_valid  output  1  slave command valid
s_icb_cmd_ready  input  1  slave command ready
s_icb_cmd_read  output  1  slave read
s_icb_cmd_addr  output  AW  slave address
s_icb_cmd_wdata  output  DW  slave write data
s_icb_cmd_wmask  output  DW/8  slave byte mask
s_icb_rsp_valid  input  1  slave response valid
s_icb_rsp_ready  output  1  slave response ready
s_icb_rsp_rdata  input  DW  slave read data
s_icb_rsp_err  input  1  slave response error
arb_orphan_err  output  1  sticky: slave response seen with empty ID FIFO

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous active-low.
- State registers: rr_last (last granted master, 1 bit), ID FIFO (OUTS_DEPTH entries x 1 bit), wr_ptr, rd_ptr, count (0..OUTS_DEPTH), orphan flag.
- Reset values: rr_last=1 (m0 wins the first tie), pointers=0, count=0, orphan=0.
- Outputs after reset:
  - all m*_rsp_valid=0 and s_icb_cmd_valid=0 while masters are idle;
  - arb_orphan_err=0.
- Grant (combinational, same cycle):
  - only one master valid -> that master;
  - both valid -> the master != rr_last;
  - no master valid -> grant defaults to m0 for the cmd payload mux, with s_icb_cmd_valid=0.
- full = (count==OUTS_DEPTH).
- s_icb_cmd_valid = (m0_valid|m1_valid) & !full.
- s_icb_cmd_read/addr/wdata/wmask come from the granted master.
- mX_icb_cmd_ready = grant==X & s_icb_cmd_ready & !full; the non-granted master's ready is 0.
- Command handshake (s_icb_cmd_valid & s_icb_cmd_ready):
  - push grant ID at wr_ptr;
  - wr_ptr increments, wrapping at OUTS_DEPTH-1 -> 0;
  - rr_last <= grant.
- full blocks push even if a pop occurs in the same cycle; there is no bypass. This keeps cmd_ready free of any rsp-path dependency.
- Response routing by FIFO head (fifo[rd_ptr]) when count>0:
  - the owner's rsp_valid = s_icb_rsp_valid; the other master's rsp_valid = 0;
  - rdata/err are passed to both masters unqualified;
  - s_icb_rsp_ready = owner's rsp_ready.
- Response handshake (s_icb_rsp_valid & s_icb_rsp_ready): rd_ptr increments with wrap; count decrements.
- Simultaneous push and pop (when not full): count unchanged, both pointers advance.
- Empty-FIFO response (count==0 & s_icb_rsp_valid):
  - s_icb_rsp_ready=1, so the response is drained;
  - no master rsp_valid;
  - orphan flag set; it is sticky until reset.
- Latency: zero added cycles on both the command and response paths (pure muxing); throughput is 1 cmd/cycle until OUTS_DEPTH are outstanding.
- Master valids held without a grant must be retained by the master; the arbiter never drops a request.
- Reset asserted mid-operation: all state is cleared immediately and in-flight responses are forgotten; a post-reset slave response raises arb_orphan_err.

Test Plan:
1. Reset, then m0 read addr 0x010 only, slave ready, rsp 1 cycle later rdata 0xDEADBEEF -> m0_cmd_ready=1 same cycle; m0_rsp_valid with 0xDEADBEEF; m1_rsp_valid=0 throughout.
2. m0 and m1 both valid continuously for 4 commands, slave always ready, rsp 1 cycle later -> grants m0,m1,m0,m1; responses route m0,m1,m0,m1; count never exceeds 2.
3. OUTS_DEPTH=2, slave rsp stalled (s_rsp_valid=0) -> exactly 2 cmds accepted, then both cmd_ready=0 and s_cmd_valid=0. Release 1 rsp -> no new cmd in the pop cycle; the 3rd cmd is accepted the following cycle.
4. m1 write wdata 0x12345678 wmask 4'b0011 addr 0x004 -> slave sees identical payload; m1 rsp err=0. Hold m1_rsp_ready=0 for 3 cycles -> s_icb_rsp_ready=0 for those cycles; no loss.
5. s_icb_rsp_valid=1 with nothing outstanding -> s_icb_rsp_ready=1; no master rsp_valid; arb_orphan_err=1 and stays 1 until rst_n low.
6. Assert rst_n low with 2 outstanding, release -> count=0; rr_last=1; next tie grants m0.
